// File: rtl/addsub_serial_nbit_if.sv
// addsub_serial_nbit_if: operand/result bundle for the serial add/subtract unit.
//   start, sel, a, b      : request side, driven by the master (operand registers)
//   busy, done, s, co,
//   ovf, zero             : response side, driven by the slave (the unit)
// WIDTH must match the WIDTH of the attached addsub_serial_nbit.
interface addsub_serial_nbit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zero;

    modport master (
        output start, sel, a, b,
        input  busy, done, s, co, ovf, zero
    );

    modport slave (
        input  start, sel, a, b,
        output busy, done, s, co, ovf, zero
    );
endinterface

// File: rtl/addsub_serial_nbit.sv
// addsub_serial_nbit: multi-cycle add/subtract, DIGIT bits per clock through one ripple slice.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : addsub_serial_nbit_if.slave
//          start/sel/a/b in; busy/done/s/co/ovf/zero out
// A request is accepted in IDLE or DONE; the result appears WIDTH/DIGIT cycles later with a
// one-cycle done pulse. s/co/ovf/zero hold until the next accept (s shows partial digits while
// the next operation runs).
// Build option: define ADDSUB_FLAGS_EN to compute ovf and zero; otherwise both are tied to 0.
module addsub_serial_nbit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    addsub_serial_nbit_if.slave bus
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
    logic             sel_q, carry_q, co_q;
    logic [CW-1:0]    cnt_q;
    logic             accept, last;
    logic [31:0]      base;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   dsum;

    // Current digit slice; subtract is a + ~b + 1 with the +1 preloaded into carry_q.
    always_comb begin
        base  = 32'(cnt_q) * DIGIT;
        a_dig = DIGIT'(a_q >> base);
        b_dig = DIGIT'(b_q >> base) ^ {DIGIT{sel_q}};
        dsum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        s_d   = (s_q & ~(WIDTH'({DIGIT{1'b1}}) << base))
              | (WIDTH'(dsum[DIGIT-1:0]) << base);
        last  = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (last) state_d = StDone;
            end
            StDone: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            sel_q   <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                sel_q   <= bus.sel;
                carry_q <= bus.sel;
                cnt_q   <= '0;
            end else if (state_q == StCalc) begin
                s_q     <= s_d;
                carry_q <= dsum[DIGIT];
                cnt_q   <= cnt_q + CW'(1);
                if (last) co_q <= dsum[DIGIT];
            end
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic ovf_q, zero_q;

    // Carry into the MSB is recovered as a ^ b' ^ sum at that bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!accept && state_q == StCalc && last) begin
            ovf_q  <= a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
            zero_q <= (s_d == '0);
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.s    = s_q;
    assign bus.co   = co_q;
endmodule

// File: tb/tb_addsub_serial_nbit.sv
// Self-checking bench for addsub_serial_nbit: a 16/4 instance and an 8/8 instance, directed
// corner cases plus random operands checked against an arithmetic reference model.
module tb_addsub_serial_nbit;
`ifdef ADDSUB_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    addsub_serial_nbit_if #(.WIDTH(16)) bus16 ();
    addsub_serial_nbit_if #(.WIDTH(8))  bus8 ();

    addsub_serial_nbit #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    addsub_serial_nbit #(.WIDTH(8), .DIGIT(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: w-bit modular add/subtract, flags from operand/result signs.
    function automatic void model(input int w, input logic sel, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] s,
                                  output logic co, output logic ovf, output logic zero);
        int unsigned mask, bb, full;
        logic sa, sb, ss;
        mask = (32'd1 << w) - 32'd1;
        bb   = sel ? (~32'(b)) & mask : 32'(b);
        full = 32'(a) + bb + 32'(sel);
        s    = 16'(full & mask);
        co   = 1'((full >> w) & 32'd1);
        sa   = 1'((32'(a) >> (w - 1)) & 32'd1);
        sb   = 1'((32'(b) >> (w - 1)) & 32'd1);
        ss   = 1'((32'(s) >> (w - 1)) & 32'd1);
        ovf  = FlagsEn & (sel ? (sa != sb && ss != sa) : (sa == sb && ss != sa));
        zero = FlagsEn & (s == 16'd0);
    endfunction

    task automatic wait16(output int n);
        n = 0;
        while (!bus16.done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (!bus8.done && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic res16(input string tag, input logic sel, input logic [15:0] a,
                         input logic [15:0] b);
        logic [15:0] es;
        logic eco, eov, ez;
        model(16, sel, a, b, es, eco, eov, ez);
        chk({tag, " s"}, 32'(bus16.s), 32'(es));
        chk({tag, " co"}, 32'(bus16.co), 32'(eco));
        chk({tag, " ovf"}, 32'(bus16.ovf), 32'(eov));
        chk({tag, " zero"}, 32'(bus16.zero), 32'(ez));
    endtask

    task automatic op16(input string tag, input logic sel, input logic [15:0] a,
                        input logic [15:0] b);
        int n;
        logic [15:0] held;
        bus16.start = 1'b1;
        bus16.sel   = sel;
        bus16.a     = a;
        bus16.b     = b;
        tick();
        bus16.start = 1'b0;
        bus16.a     = ~a;
        bus16.b     = ~b;
        chk({tag, " busy"}, 32'(bus16.busy), 32'd1);
        wait16(n);
        chk({tag, " latency"}, 32'(n), 32'd4);
        res16(tag, sel, a, b);
        held = bus16.s;
        tick();
        chk({tag, " done pulse"}, 32'(bus16.done), 32'd0);
        chk({tag, " busy fall"}, 32'(bus16.busy), 32'd0);
        chk({tag, " s held"}, 32'(bus16.s), 32'(held));
    endtask

    task automatic op8(input string tag, input logic sel, input logic [7:0] a,
                       input logic [7:0] b);
        int n;
        logic [15:0] es;
        logic eco, eov, ez;
        model(8, sel, 16'(a), 16'(b), es, eco, eov, ez);
        bus8.start = 1'b1;
        bus8.sel   = sel;
        bus8.a     = a;
        bus8.b     = b;
        tick();
        bus8.start = 1'b0;
        wait8(n);
        chk({tag, " latency"}, 32'(n), 32'd1);
        chk({tag, " s"}, 32'(bus8.s), 32'(es[7:0]));
        chk({tag, " co"}, 32'(bus8.co), 32'(eco));
        chk({tag, " ovf"}, 32'(bus8.ovf), 32'(eov));
        chk({tag, " zero"}, 32'(bus8.zero), 32'(ez));
        tick();
        chk({tag, " done pulse"}, 32'(bus8.done), 32'd0);
    endtask

    initial begin
        int n;
        int dones;
        bus16.start = 1'b0;
        bus16.sel   = 1'b0;
        bus16.a     = '0;
        bus16.b     = '0;
        bus8.start  = 1'b0;
        bus8.sel    = 1'b0;
        bus8.a      = '0;
        bus8.b      = '0;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("reset busy", 32'(bus16.busy), 32'd0);
        chk("reset done", 32'(bus16.done), 32'd0);
        chk("reset s", 32'(bus16.s), 32'd0);
        chk("reset co", 32'(bus16.co), 32'd0);
        chk("reset ovf", 32'(bus16.ovf), 32'd0);
        chk("reset zero", 32'(bus16.zero), 32'd0);
        chk("reset8 busy", 32'(bus8.busy), 32'd0);
        chk("reset8 s", 32'(bus8.s), 32'd0);

        // Directed corners
        op16("add 1234+0ff0", 1'b0, 16'h1234, 16'h0FF0);
        op16("add 7fff+1", 1'b0, 16'h7FFF, 16'h0001);
        op16("add ffff+1", 1'b0, 16'hFFFF, 16'h0001);
        op16("sub 5-5", 1'b1, 16'h0005, 16'h0005);
        op16("sub 3-5", 1'b1, 16'h0003, 16'h0005);
        op16("sub 8000-1", 1'b1, 16'h8000, 16'h0001);
        // Anchor the model against hand-derived results.
        op16("const", 1'b0, 16'h1234, 16'h0FF0);
        chk("const s value", 32'(bus16.s), 32'h2224);
        chk("const co value", 32'(bus16.co), 32'd0);

        // start during CALC is ignored; start during DONE accepts back-to-back
        bus16.start = 1'b1;
        bus16.sel   = 1'b0;
        bus16.a     = 16'h1111;
        bus16.b     = 16'h2222;
        tick();
        bus16.start = 1'b0;
        tick();
        bus16.start = 1'b1;
        bus16.sel   = 1'b1;
        bus16.a     = 16'hAAAA;
        bus16.b     = 16'h0001;
        tick();
        bus16.start = 1'b0;
        wait16(n);
        chk("ignore latency", 32'(n + 2), 32'd4);
        res16("ignore", 1'b0, 16'h1111, 16'h2222);
        bus16.start = 1'b1;
        bus16.sel   = 1'b1;
        bus16.a     = 16'h0100;
        bus16.b     = 16'h0200;
        tick();
        bus16.start = 1'b0;
        chk("b2b busy", 32'(bus16.busy), 32'd1);
        chk("b2b done low", 32'(bus16.done), 32'd0);
        wait16(n);
        chk("b2b spacing", 32'(n + 1), 32'd5);
        res16("b2b", 1'b1, 16'h0100, 16'h0200);
        tick();

        // Reset two cycles after accept; start held during reset is ignored
        bus16.start = 1'b1;
        bus16.sel   = 1'b0;
        bus16.a     = 16'h5678;
        bus16.b     = 16'h1111;
        tick();
        bus16.start = 1'b0;
        tick();
        rst         = 1'b1;
        bus16.start = 1'b1;
        tick();
        rst         = 1'b0;
        bus16.start = 1'b0;
        chk("rst busy", 32'(bus16.busy), 32'd0);
        chk("rst done", 32'(bus16.done), 32'd0);
        chk("rst s", 32'(bus16.s), 32'd0);
        chk("rst co", 32'(bus16.co), 32'd0);
        chk("rst ovf", 32'(bus16.ovf), 32'd0);
        chk("rst zero", 32'(bus16.zero), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus16.done) dones++;
        end
        chk("rst no done", 32'(dones), 32'd0);
        op16("after rst", 1'b0, 16'h5678, 16'h1111);

        // Random operands
        for (int i = 0; i < 24; i++) begin
            op16("rand16", 1'($urandom), 16'($urandom), 16'($urandom));
        end

        // Single-digit instance
        op8("add8 80+80", 1'b0, 8'h80, 8'h80);
        chk("add8 const s", 32'(bus8.s), 32'h00);
        chk("add8 const co", 32'(bus8.co), 32'd1);
        op8("sub8 7f-ff", 1'b1, 8'h7F, 8'hFF);
        for (int i = 0; i < 12; i++) begin
            op8("rand8", 1'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/addsub_serial_nbit.md
# addsub_serial_nbit

Parametrised, multi-cycle add/subtract unit. It is the successor to the fixed 4-bit ripple adder/subtractor. Operands of WIDTH bits are processed DIGIT bits per clock through a single DIGIT-wide ripple slice, which trades latency for area. It sits between the operand registers and the result/flag registers of the datapath and uses a start/busy/done handshake.

## Interface
- WIDTH, 16: operand and result width in bits. Must be ≥ 2.
- DIGIT, 4: bits processed per clock. WIDTH must be an integer multiple of DIGIT. N = WIDTH/DIGIT digit steps.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the unit can accept (see Operation).
- sel  in  1  0 = add (a+b), 1 = subtract (a−b); latched with the operands.
- a  in  WIDTH  operand A; latched on accept.
- b  in  WIDTH  operand B; latched on accept.
- busy  out  1  high while an operation is in flight (CALC and DONE states).
- done  out  1  one-cycle pulse: results valid.
- s  out  WIDTH  sum/difference.
- co  out  1  carry out of the MSB. For subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  s == 0.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: start=1 accepts the request.
  - Latch a, b and sel.
  - digit counter ← 0; carry register ← sel.
  - Go to CALC.
- CALC: each clock processes digit k (bits k·DIGIT+DIGIT−1 … k·DIGIT).
  - Digit sum: a_k + (b_k XOR {DIGIT{sel}}) + carry.
  - Write the digit result into s_k and update the carry register.
  - After digit N−1, go to DONE.
- DONE: done=1 for exactly this cycle. co, ovf and zero update on entry to DONE.
  - start=1 here accepts a new request (back-to-back), going to CALC.
  - start=0 returns to IDLE.
- Flags:
  - ovf = (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1).
  - zero is evaluated on the final s.
- Outputs s, co, ovf and zero are held from DONE until the next accept.
  - While the next operation is in CALC, s shows partial digits. Consumers sample only on done.
- start while in CALC: ignored, with no effect on the operation in flight.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0.
  - s = 0, co = 0, ovf = 0, zero = 0.
  - Internal operand, carry and counter registers = 0.
- Latency:
  - start is accepted at edge E0.
  - done is high in the cycle after edge EN, i.e. N cycles after accept.
  - Next accept: at edge E(N+1) when start is held (back-to-back throughput N+1 cycles). Otherwise at the first edge with start=1 after returning to IDLE.
- busy goes high in the cycle after E0 and falls in the cycle after done.
- Reset mid-operation: rst=1 at any edge aborts the operation and forces all reset values. start is ignored while rst=1.
- DIGIT == WIDTH: N=1. done follows in the cycle after the first CALC edge.

## Configuration
- ADDSUB_FLAGS_EN
  - Defined: ovf and zero are computed as above.
  - Undefined: the ovf/zero logic is removed and both ports are tied to 0. Port list and all timing are unchanged; s, co, busy and done behave identically.

## Test plan
- WIDTH=16, DIGIT=4, add 0x1234+0x0FF0 -> s=0x2224, co=0, ovf=0, zero=0; done exactly 4 cycles after accept, for 1 cycle.
- Add 0x7FFF+0x0001 -> s=0x8000, co=0, ovf=1. Add 0xFFFF+0x0001 -> s=0x0000, co=1, ovf=0, zero=1.
- Subtract 0x0005−0x0005 -> s=0x0000, co=1, zero=1. Subtract 0x0003−0x0005 -> s=0xFFFE, co=0, ovf=0. Subtract 0x8000−0x0001 -> s=0x7FFF, ovf=1.
- Pulse start again 2 cycles after accept with different operands -> ignored; the first result is unchanged. Then assert start during the done cycle -> back-to-back accept; second done arrives 5 cycles after the first.
- rst=1 two cycles after accept -> next cycle busy=0, done=0, s=0, flags=0. No done pulse follows; a fresh start then completes normally.
- WIDTH=8, DIGIT=8: add 0x80+0x80 -> s=0x00, co=1, ovf=1, zero=1, with done 1 cycle after accept. Repeat the first scenario with ADDSUB_FLAGS_EN undefined -> ovf=zero=0 throughout.
